// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared state codes, status word layout and marker for the debug step controller
package debug_pkg;

    typedef enum logic [3:0] {
        ST_HALT  = 4'h1,
        ST_RUN   = 4'h2,
        ST_STEP  = 4'h3,
        ST_BREAK = 4'h4
    } state_e;

    localparam int WORD_STATE_MSB = 31;
    localparam int WORD_STATE_LSB = 28;
    localparam int WORD_COUNT_MSB = 27;
    localparam int WORD_COUNT_LSB = 16;
    localparam int WORD_PROBE_MSB = 15;
    localparam int WORD_PROBE_LSB = 0;

    localparam logic [31:0] DEBUG_MARKER = 32'hFFFF_FFFF;

    function automatic logic [31:0] pack_word(input state_e st, input logic [11:0] cnt,
                                              input logic [15:0] prb);
        logic [31:0] w;
        w = '0;
        w[WORD_STATE_MSB:WORD_STATE_LSB] = st;
        w[WORD_COUNT_MSB:WORD_COUNT_LSB] = cnt;
        w[WORD_PROBE_MSB:WORD_PROBE_LSB] = prb;
        // Legal state codes keep bit 31 clear; the guard keeps the marker unreachable by construction.
        return (w == DEBUG_MARKER) ? (w & 32'h7FFF_FFFF) : w;
    endfunction

endpackage

// File: rtl/debug_bp_match.sv
// rtl/debug_bp_match.sv - combinational masked breakpoint compare of the probe bus
module debug_bp_match (
    input  logic        bp_en_i,
    input  logic [15:0] bp_value_i,
    input  logic [15:0] bp_mask_i,
    input  logic [15:0] probe_i,
    output logic        match_o
);

    assign match_o = bp_en_i && (((probe_i ^ bp_value_i) & bp_mask_i) == 16'h0000);

endmodule

// File: rtl/debug_step_ctrl.sv
// rtl/debug_step_ctrl.sv - run/halt/step/breakpoint clock-enable controller; breakpoint logic under DEBUG_STEP_BREAKPOINT_EN
module debug_step_ctrl
    import debug_pkg::*;
#(
    parameter int STEP_CYCLES = 1,
    parameter bit RESET_RUN   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        bp_en,
    input  logic [15:0] bp_value,
    input  logic [15:0] bp_mask,
    input  logic [15:0] probe,
    output logic        core_en,
    output logic        halted,
    output logic        bp_hit,
    output logic [31:0] step_count,
    output logic [31:0] debug_wireout
);

    localparam state_e RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        core_en_q, core_en_d;
    logic        halted_q, halted_d;
    logic [31:0] step_count_q, step_count_d;
    logic [31:0] wireout_q, wireout_d;
    logic        bp_fire;

`ifdef DEBUG_STEP_BREAKPOINT_EN
    logic bp_match;
    logic bp_hit_q, bp_hit_d;
    logic suppress_q, suppress_d;

    debug_bp_match u_bp_match (
        .bp_en_i    (bp_en),
        .bp_value_i (bp_value),
        .bp_mask_i  (bp_mask),
        .probe_i    (probe),
        .match_o    (bp_match)
    );

    // The first RUN cycle after BREAK must not re-trigger on the same probe value.
    assign bp_fire    = (state_q == ST_RUN) && bp_match && !suppress_q;
    assign bp_hit_d   = bp_fire || (bp_hit_q && !(run_req || step_req));
    assign suppress_d = (state_q == ST_BREAK) && (state_d == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_hit_q   <= 1'b0;
            suppress_q <= 1'b0;
        end else begin
            bp_hit_q   <= bp_hit_d;
            suppress_q <= suppress_d;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_value, bp_mask};
    assign bp_fire   = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            cnt_q        <= 8'd0;
            core_en_q    <= RESET_RUN;
            halted_q     <= !RESET_RUN;
            step_count_q <= 32'd0;
            wireout_q    <= pack_word(RESET_STATE, 12'h000, 16'h0000);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_en_q    <= core_en_d;
            halted_q     <= halted_d;
            step_count_q <= step_count_d;
            wireout_q    <= wireout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_HALT, ST_BREAK: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                    cnt_d   = 8'(STEP_CYCLES);
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (bp_fire) begin
                    state_d = ST_BREAK;
                end
            end
            ST_STEP: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    cnt_d   = 8'd0;
                end else begin
                    // cnt_q counts enabled cycles still owed, including the current one.
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_comb begin
        core_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
        halted_d     = !core_en_d;
        step_count_d = step_count_q + {31'd0, core_en_q};
        wireout_d    = pack_word(state_d, step_count_d[11:0], probe);
    end

    assign core_en       = core_en_q;
    assign halted        = halted_q;
    assign step_count    = step_count_q;
    assign debug_wireout = wireout_q;

endmodule

// File: doc/debug_step_ctrl.md
# debug_step_ctrl

Single-step execution controller upstream of the debug capture unit. Gates the firmware under test through a clock-enable and supports free-run, halt, N-cycle step and masked breakpoint. Every cycle it builds the 32-bit `debug_wireout` status word that the capture FIFO samples. The word never equals the capture frame marker 32'hFFFF_FFFF.

## Interface
- `STEP_CYCLES`, default 1: `core_en` cycles issued per step request (1..255).
- `RESET_RUN`, default 0: 0 leaves reset in HALT, 1 leaves reset in RUN.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `run_req` in 1: one-cycle pulse; enter RUN.
- `halt_req` in 1: one-cycle pulse; enter HALT.
- `step_req` in 1: one-cycle pulse; issue one step.
- `bp_en` in 1: breakpoint enable (level).
- `bp_value` in 16: breakpoint compare value.
- `bp_mask` in 16: compare mask; 1 = bit compared.
- `probe` in 16: firmware probe bus, synchronous to `clk`.
- `core_en` out 1: clock-enable to the firmware under debug.
- `halted` out 1: high in HALT or BREAK.
- `bp_hit` out 1: sticky; set on breakpoint, cleared by `run_req` or `step_req`.
- `step_count` out 32: count of `core_en`-high cycles; wraps at 2^32.
- `debug_wireout` out 32: status word for the capture unit.

## Operation
- States and codes:
  - HALT = 4'h1
  - RUN = 4'h2
  - STEP = 4'h3
  - BREAK = 4'h4
  - Codes 4'h0 and 4'h5..4'hF are never produced.
- Word format: [31:28] state code, [27:16] `step_count[11:0]`, [15:0] `probe`. Bit 31 is always 0, so the word is never all-ones.
- HALT / BREAK:
  - `core_en` = 0.
  - `step_req` → STEP and load the step counter with `STEP_CYCLES`.
  - `run_req` → RUN.
- STEP:
  - `core_en` = 1 each cycle while the step counter is nonzero; the counter decrements each cycle.
  - When it reaches 0 → HALT.
  - `halt_req` aborts to HALT immediately.
  - `run_req` and `step_req` are ignored in STEP.
  - The breakpoint is not evaluated in STEP.
- RUN:
  - `core_en` = 1 every cycle.
  - `halt_req` → HALT.
  - A breakpoint match → BREAK and set `bp_hit`.
  - `step_req` is ignored.
- Breakpoint match: `bp_en && ((probe ^ bp_value) & bp_mask) == 0`.
- Breakpoint suppression:
  - The first RUN cycle after leaving BREAK ignores the match.
  - With `bp_mask` = 0 and `bp_en` = 1, every RUN cycle after the suppressed one matches.
- Simultaneous requests: priority is `halt_req` > breakpoint > `run_req` > `step_req`.
- `step_count` increments by 1 in every cycle in which `core_en` is 1, with natural 32-bit wrap.

## Timing
- All outputs are registered.
- A request sampled at edge N takes effect on outputs at edge N+1:
  - `step_req` at N → `core_en` high for cycles N+1..N+`STEP_CYCLES`.
  - `halted` low from N+1 until the step completes.
- Breakpoint: `probe` matching at edge N gives `core_en` = 0, `halted` = 1, `bp_hit` = 1 at N+1. The firmware therefore executes exactly one enabled cycle past the match.
- `debug_wireout` reflects `probe` and state sampled at edge N, valid after edge N+1 (one-cycle latency).
- Reset values:
  - State: HALT (or RUN if `RESET_RUN` = 1).
  - `core_en` = `RESET_RUN`.
  - `halted` = !`RESET_RUN`.
  - `bp_hit` = 0.
  - `step_count` = 0.
  - `debug_wireout` = {state code, 28'h0}.
- Reset asserted mid-step or mid-run: outputs go to reset values asynchronously. No partial step is resumed after release.

## Configuration
- `DEBUG_STEP_BREAKPOINT_EN` defined: breakpoint compare, BREAK state and `bp_hit` are present.
- Not defined:
  - `bp_en`, `bp_value` and `bp_mask` are ignored.
  - `bp_hit` is tied 0.
  - BREAK is unreachable; the state code 4'h4 never appears.
  - All other behaviour is identical.

## Structure
- Shared package `debug_pkg`:
  - State code constants.
  - Word field positions: state [31:28], count [27:16], probe [15:0].
  - `DEBUG_MARKER` = 32'hFFFF_FFFF.
- Sub-module `debug_bp_match`: combinational masked compare, instantiated only under `DEBUG_STEP_BREAKPOINT_EN`.

## Test plan
- Reset release, `RESET_RUN` = 0:
  - `halted` = 1, `core_en` = 0, `debug_wireout` = 32'h1000_0000.
  - `step_count` stays 0 for 100 cycles.
- `STEP_CYCLES` = 3, one `step_req` pulse:
  - `core_en` high exactly 3 cycles starting one cycle after the pulse.
  - `step_count` = 3, then HALT.
- RUN with `bp_en` = 1, `bp_mask` = 16'h00FF, `bp_value` = 16'h0042; drive `probe` = 16'hAB42 at cycle 10:
  - BREAK at cycle 11, `bp_hit` = 1, `debug_wireout[31:28]` = 4'h4.
  - `step_count` = 11 when counted from RUN entry.
- Same cycle `run_req` + `halt_req` in HALT: state stays HALT, `core_en` = 0.
- Preload `step_count` to 32'hFFFF_FFFE by run duration, then step 3 cycles: wraps to 32'h0000_0001.
- Scan all states with `probe` = 16'hFFFF, `bp_mask` = 0: `debug_wireout` never equals 32'hFFFF_FFFF.
